muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the operand-forwarding logic. It consumes the forwarded operands `rs1_data_EX` and `rs2_data_EX` and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While it works, it holds the pipeline with `stall_EX`. It returns a registered 32-bit result with a one-cycle `done` pulse, which the EX result mux selects.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Operands are captured as magnitudes at accept; the sign fix-up is applied on the edge into DONE.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data_EX,
  input  logic [XLEN-1:0] rs2_data_EX,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall_EX
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Accept-time decode of the incoming operands
  logic            rs1_signed, rs2_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  assign rs1_signed = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
  assign rs2_signed = (funct3 == 3'b000 || funct3 == 3'b001 ||
                       funct3 == 3'b100 || funct3 == 3'b110);
  assign sa    = rs1_signed & rs1_data_EX[XLEN-1];
  assign sb    = rs2_signed & rs2_data_EX[XLEN-1];
  assign a_mag = sa ? -rs1_data_EX : rs1_data_EX;
  assign b_mag = sb ? -rs2_data_EX : rs2_data_EX;

  assign div_zero = funct3[2] & (rs2_data_EX == '0);
  assign div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
                    (rs1_data_EX == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_EX == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? rs1_data_EX : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration: multiply keeps {partial product, remaining multiplier},
  // divide keeps {partial remainder, remaining dividend / quotient bits}.
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod;
  logic [XLEN-1:0]   quo, rem, fixed;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
  assign div_next = diff[XLEN+1] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign step     = op_q[2] ? div_next : mul_next;

  assign prod = neg_q ? -step : step;
  assign quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
  assign rem  = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

  always_comb begin
    fixed = '0;
    if (op_q[2])               fixed = op_q[1] ? rem : quo;
    else if (op_q[1:0] == '0) fixed = prod[XLEN-1:0];
    else                       fixed = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d   = funct3;
          neg_d  = (funct3 == 3'b110) ? sa : (sa ^ sb);
          opnd_d = funct3[2] ? b_mag : a_mag;
          acc_d  = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
          cnt_d  = '0;
          if (special) begin
            state_d  = StDone;
            result_d = special_res;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(XLEN-1)) begin
          state_d  = StDone;
          result_d = fixed;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result   = result_q;
  assign done     = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign stall_EX = ((state_q == StIdle) & start & ~flush) | (state_q == StRun);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a monitor checks each done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data_EX = '0;
  logic [31:0] rs2_data_EX = '0;
  logic [31:0] result;
  logic        done, busy, stall_EX;

  int ntests = 0;
  int nfail  = 0;
  int done_seen = 0;
  int ops_pushed = 0;
  logic [31:0] expq[$];
  logic [31:0] last_exp = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX),
    .result(result), .done(done), .busy(busy), .stall_EX(stall_EX)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      ntests++;
      if (expq.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_done: got result %h expected no done", result);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        if (result !== e) begin
          nfail++;
          $display("FAIL result: got %h expected %h", result, e);
        end
      end
    end
  end

  // Issue one op with start held until DONE; check done cycle and stall length
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_cyc,
                        input bit scramble);
    int dc, stalls;
    dc = -1;
    stalls = 0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; rs1_data_EX = a; rs2_data_EX = b;
    expq.push_back(exp);
    ops_pushed++;
    last_exp = exp;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall_EX) stalls++;
      if (done) begin
        dc = c;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        rs1_data_EX = $urandom;
        rs2_data_EX = $urandom;
      end
    end
    if (dc < 0) expq.delete();
    check({name, "_done_cycle"}, 32'(dc), 32'(exp_cyc));
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_cyc));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #3;
    check("reset_result", result, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_stall", {31'b0, stall_EX}, 32'h0);
    #9 rst = 1'b0;

    run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("divu",    3'b101, 32'd100,      32'd7,        32'd14,       33, 0);
    run_op("remu",    3'b111, 32'd100,      32'd7,        32'd2,        33, 0);
    run_op("div0",    3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run_op("remu0",   3'b111, 32'd5,        32'd0,        32'd5,        1,  0);
    run_op("divovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
    run_op("removf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1,  0);
    run_op("cap_divu", 3'b101, 32'd100,     32'd7,        32'd14,       33, 1);
    run_op("cap_mul", 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1);

    // Flush at RUN iteration 10 (cycle 10 after accept)
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b011; rs1_data_EX = 32'h12345678; rs2_data_EX = 32'h9ABCDEF0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_stall", {31'b0, stall_EX}, 32'h0);
    check("flush_result_kept", result, last_exp);
    repeat (40) @(posedge clk);
    run_op("after_flush", 3'b101, 32'd1000, 32'd10, 32'd100, 33, 0);

    // Asynchronous reset mid-RUN
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; rs1_data_EX = 32'd3; rs2_data_EX = 32'd5;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1; start = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_stall", {31'b0, stall_EX}, 32'h0);
    check("arst_result", result, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (40) @(posedge clk);
    run_op("after_reset", 3'b000, 32'd3, 32'd5, 32'd15, 33, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_count", 32'(done_seen), 32'(ops_pushed));
    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
